apple_spawner: RTL
==================

# apple_spawner

Producer side of the apple-position interface. Generates pseudo-random on-grid apple coordinates and holds each apple until the snake head lands on it. On consumption it emits a one-cycle eaten pulse, parks the apple off-grid so the score consumer sees exactly one match cycle, and then places a new apple that does not coincide with the head. It sits between the game controller (`gameOver`), the snake head register (`snakeX`/`snakeY`) and the score/length logic (`apple1X`/`apple1Y`).

## Interface
Parameters:
- X_MAX, 79, largest legal X coordinate; 63 <= X_MAX <= 126
- Y_MAX, 59, largest legal Y coordinate; 0 <= Y_MAX <= 126
- SEED, 16'h0001, LFSR reset value; a value of 0 is replaced by 16'hACE1

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high; overrides every other input
- gameOver  input  1  when high, freezes the block until the next reset
- snakeX  input  7  X of the snake head
- snakeY  input  7  Y of the snake head
- apple1X  output  7  apple X (registered); 7'h7F when no apple is placed
- apple1Y  output  7  apple Y (registered); 7'h7F when no apple is placed
- appleValid  output  1  high while an on-grid apple is placed
- eaten  output  1  registered one-cycle pulse per consumed apple
- appleCount  output  7  apples consumed since reset; saturates at 127

## Operation
- **LFSR:** 16-bit Fibonacci register, shifted as lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Advances every cycle, including while frozen.
  - Reset loads SEED, or 16'hACE1 when SEED is 0.
- **Candidate:** computed from the current LFSR value.
  - rawX = lfsr[6:0], rawY = lfsr[14:8].
  - Fold: if raw > MAX, use raw - (MAX+1). If the folded value is still > MAX, reject the candidate.
  - Also reject if (candX, candY) == (snakeX, snakeY).
- **SPAWN state:**
  - A valid candidate is registered into apple1X/Y with appleValid=1, and the state moves to PLACED.
  - A rejected candidate leaves the outputs unchanged and the state in SPAWN; the next LFSR value is tried on the following cycle.
  - There is no retry limit.
- **PLACED state:** if snakeX==apple1X and snakeY==apple1Y:
  - apple1X/Y <= 7'h7F, appleValid <= 0, eaten <= 1.
  - appleCount increments unless it is already 127.
  - State moves to SPAWN.
  - Otherwise the apple holds its position.
- **FROZEN state:** entered from any state when gameOver=1.
  - apple1X/Y and appleValid hold their current values.
  - eaten is 0 and appleCount holds.
  - The only exit is reset.
- **eaten:** 0 in every cycle except the one following a detected eat.
- **Sentinel:** 7'h7F is never a legal coordinate, because both MAX values are <= 126. The consumer's compare therefore cannot match while the block is in SPAWN.

## Timing
- **Reset values:** apple1X = apple1Y = 7'h7F, appleValid = 0, eaten = 0, appleCount = 0, state = SPAWN.
- **First placement:** in the first cycle after reset deasserts, the block evaluates the candidate from SEED. If accepted, the apple is visible from the next cycle, so the minimum latency is 1 cycle after the reset cycle.
- **Eat sequence:** the match is detected combinationally in cycle N.
  - N+1: eaten=1, apple = 7F/7F, in SPAWN.
  - N+2 at the earliest: new apple visible, appleValid=1.
  - Consumers see exactly one matching cycle (N) per apple.
- **Candidate rejection:** each rejected candidate adds 1 cycle of latency.
- **gameOver together with a match:** gameOver wins. There is no eaten pulse, no count change, and the apple holds.
- **gameOver in SPAWN:** the block freezes with the apple at 7F/7F and appleValid=0.
- **Reset at any point:** including mid-SPAWN or while FROZEN, reset restores every output to its reset value on that edge.
- **Head still on the old apple position in N+1:** no effect, because the outputs hold the sentinel.

## Test plan
- **First placement:** SEED=1, head (5,5), reset 2 cycles then released -> cycle 1 candidate (1,0) accepted; apple1X=1, apple1Y=0, appleValid=1 from cycle 2; eaten=0, appleCount=0.
- **Collision retry:** SEED=1, head held at (1,0) -> candidate (1,0) rejected; next LFSR 16'h0002 gives (2,0), visible one cycle later than in the first-placement case.
- **Fold:** SEED=16'h0064, head (0,5) -> rawX 100 folds to 20; apple (20,0) placed. SEED=16'h7F00 -> rawY 127 folds to 67 > 59 -> rejected.
- **Eat:** apple at (1,0); drive head (1,0) for 3 cycles -> eaten high for exactly 1 cycle; apple 7F/7F for at least 1 cycle; appleCount=1; new apple differs from the head; no second eaten pulse.
- **gameOver:** raise gameOver in the same cycle the head matches the apple -> no eaten pulse, appleCount unchanged, apple holds. Later head changes and matches have no effect until reset, and reset restores 7F/7F/0/0.
- **Saturation:** 130 consecutive eats -> appleCount stops at 127; eaten still pulses for each eat.

Source files
------------

// File: rtl/apple_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : apple_spawner
//  Description : Places pseudo-random on-grid apples for the snake game and
//                holds each one until the snake head lands on it. When an
//                apple is eaten, the block pulses eaten, parks the apple at
//                the off-grid sentinel 7'h7F for one cycle, and then places a
//                new apple that does not coincide with the head.
//
//  Ports
//    clk         in   1  system clock, rising-edge
//    reset       in   1  synchronous active-high reset, overrides all inputs
//    gameOver    in   1  freezes the block until the next reset
//    snakeX      in   7  snake head X
//    snakeY      in   7  snake head Y
//    apple1X     out  7  apple X, 7'h7F when no apple is placed
//    apple1Y     out  7  apple Y, 7'h7F when no apple is placed
//    appleValid  out  1  high while an on-grid apple is placed
//    eaten       out  1  one-cycle pulse per consumed apple
//    appleCount  out  7  apples consumed since reset, saturating at 127
//
//  Revision    : 1.0  initial release
// ============================================================================
module apple_spawner #(
    parameter int          X_MAX = 79,
    parameter int          Y_MAX = 59,
    parameter logic [15:0] SEED  = 16'h0001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gameOver,
    input  logic [6:0] snakeX,
    input  logic [6:0] snakeY,
    output logic [6:0] apple1X,
    output logic [6:0] apple1Y,
    output logic       appleValid,
    output logic       eaten,
    output logic [6:0] appleCount
);

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] C_SEED      = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [7:0]  C_X_MAX     = 8'(X_MAX);
    localparam logic [7:0]  C_Y_MAX     = 8'(Y_MAX);
    localparam logic [6:0]  C_OFF_GRID  = 7'h7F;
    localparam logic [6:0]  C_COUNT_MAX = 7'd127;

    typedef enum logic [1:0] {
        S_SPAWN  = 2'd0,
        S_PLACED = 2'd1,
        S_FROZEN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_lfsr;
    logic [6:0]  w_x_nxt;
    logic [6:0]  w_y_nxt;
    logic        w_valid_nxt;
    logic        w_eaten_nxt;
    logic [6:0]  w_count_nxt;

    // ------------------------------------------------------------------------
    // Candidate generation. Raw values are 0..127; one subtraction of
    // (MAX+1) folds most out-of-range values back onto the grid, and anything
    // still out of range is simply rejected and retried next cycle.
    // ------------------------------------------------------------------------
    logic [7:0] w_raw_x;
    logic [7:0] w_raw_y;
    logic [7:0] w_fold_x;
    logic [7:0] w_fold_y;
    logic       w_cand_ok;
    logic       w_head_on_apple;

    assign w_raw_x  = {1'b0, r_lfsr[6:0]};
    assign w_raw_y  = {1'b0, r_lfsr[14:8]};
    assign w_fold_x = (w_raw_x > C_X_MAX) ? (w_raw_x - (C_X_MAX + 8'd1)) : w_raw_x;
    assign w_fold_y = (w_raw_y > C_Y_MAX) ? (w_raw_y - (C_Y_MAX + 8'd1)) : w_raw_y;

    assign w_cand_ok = (w_fold_x <= C_X_MAX) && (w_fold_y <= C_Y_MAX) &&
                       !((w_fold_x[6:0] == snakeX) && (w_fold_y[6:0] == snakeY));

    assign w_head_on_apple = (snakeX == apple1X) && (snakeY == apple1Y);

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = apple1X;
        w_y_nxt     = apple1Y;
        w_valid_nxt = appleValid;
        w_eaten_nxt = 1'b0;
        w_count_nxt = appleCount;

        // gameOver takes priority over a simultaneous eat or placement.
        if (gameOver) begin
            w_state_nxt = S_FROZEN;
        end else begin
            case (r_state)
                S_SPAWN: begin
                    if (w_cand_ok) begin
                        w_x_nxt     = w_fold_x[6:0];
                        w_y_nxt     = w_fold_y[6:0];
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_PLACED;
                    end
                end
                S_PLACED: begin
                    if (w_head_on_apple) begin
                        // Park off-grid so the consumer sees one match cycle only.
                        w_x_nxt     = C_OFF_GRID;
                        w_y_nxt     = C_OFF_GRID;
                        w_valid_nxt = 1'b0;
                        w_eaten_nxt = 1'b1;
                        if (appleCount != C_COUNT_MAX) begin
                            w_count_nxt = appleCount + 7'd1;
                        end
                        w_state_nxt = S_SPAWN;
                    end
                end
                S_FROZEN: begin
                    w_state_nxt = S_FROZEN;
                end
                default: begin
                    w_state_nxt = S_SPAWN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers. The LFSR keeps running even when frozen.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_SPAWN;
            r_lfsr     <= C_SEED;
            apple1X    <= C_OFF_GRID;
            apple1Y    <= C_OFF_GRID;
            appleValid <= 1'b0;
            eaten      <= 1'b0;
            appleCount <= 7'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_lfsr     <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
            apple1X    <= w_x_nxt;
            apple1Y    <= w_y_nxt;
            appleValid <= w_valid_nxt;
            eaten      <= w_eaten_nxt;
            appleCount <= w_count_nxt;
        end
    end

endmodule
`default_nettype wire
